// File: rtl/cmp_seq_ctrl_if.sv
// Comparator request/result bundle.
// Master drives start and operands; slave returns status and result.
interface cmp_seq_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] max_out;
  logic         a_gt_b;
  logic         equal;

  modport master (
    output start, a, b,
    input  busy, done, max_out, a_gt_b, equal
  );

  modport slave (
    input  start, a, b,
    output busy, done, max_out, a_gt_b, equal
  );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Bit-serial MSB-first magnitude comparator, one bit pair per cycle.
// CMP_EARLY_EXIT_EN: stop at the first differing bit instead of all W.
module cmp_seq_ctrl #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  cmp_seq_ctrl_if.slave   bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [IW-1:0]  idx;
  logic [W-1:0]   max_q;
  logic           gt_q;
  logic           eq_q;
  logic           busy_q;
  logic           done_q;
`ifndef CMP_EARLY_EXIT_EN
  logic           found;
`endif

  logic a_bit;
  logic b_bit;
  logic diff;

  assign a_bit = a_r[idx];
  assign b_bit = b_r[idx];
  assign diff  = a_bit ^ b_bit;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.max_out = max_q;
  assign bus.a_gt_b  = gt_q;
  assign bus.equal   = eq_q;

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= IW'(W - 1);
      max_q  <= '0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      found  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            idx    <= IW'(W - 1);
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
            busy_q <= 1'b1;
`ifndef CMP_EARLY_EXIT_EN
            found  <= 1'b0;
`endif
            state  <= SCAN;
          end
        end
        SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
          if (diff) begin
            gt_q   <= a_bit;
            max_q  <= a_bit ? a_r : b_r;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (idx == '0) begin
            eq_q   <= 1'b1;
            gt_q   <= 1'b0;
            max_q  <= a_r;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          if (diff && !found) begin
            gt_q  <= a_bit;
            max_q <= a_bit ? a_r : b_r;
            found <= 1'b1;
          end
          if (idx == '0) begin
            if (!found && !diff) begin
              eq_q  <= 1'b1;
              gt_q  <= 1'b0;
              max_q <= a_r;
            end
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`endif
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Randomized bench for cmp_seq_ctrl against a plain-arithmetic model.
// Latency expectations follow CMP_EARLY_EXIT_EN when defined.
module tb_cmp_seq_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cmp_seq_ctrl_if #(.W(W)) bus ();

  cmp_seq_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
    if (x == y) return W + 1;
    for (int k = W - 1; k >= 0; k--)
      if (x[k] != y[k]) return W - k + 1;
    return W + 1;
`else
    return W + 1;
`endif
  endfunction

  // One comparison; start is randomly re-asserted and operands are
  // scrambled while busy, and none of that may disturb the result.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] emax;
    int lat, cyc, ndone;
    bit got;
    emax  = (x >= y) ? x : y;
    lat   = exp_lat(x, y);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    cyc = 1;
    got = 0;
    ndone = 0;
    while (!got && cyc <= W + 4) begin
      if (bus.done) begin
        got = 1;
        ndone++;
        bus.start = 1'b0;
        chk("latency", cyc, lat);
        chk("max_out", bus.max_out, emax);
        chk("a_gt_b", bus.a_gt_b, x > y);
        chk("equal", bus.equal, x == y);
        chk("busy_done", bus.busy, 1);
      end else begin
        bus.start = (cyc == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.a = (cyc == 2) ? '1 : W'($urandom);
        bus.b = W'($urandom);
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.a = W'($urandom);
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
      chk("idle_busy", bus.busy, 0);
      chk("hold_max", bus.max_out, emax);
      chk("hold_gt", bus.a_gt_b, x > y);
      chk("hold_eq", bus.equal, x == y);
    end
    chk("one_done", ndone, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int cyc;
    bit got;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_max", bus.max_out, 0);
    chk("rst_gt", bus.a_gt_b, 0);
    chk("rst_eq", bus.equal, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_hold", bus.busy, 0);

    run_op(8'h80, 8'h7F);
    run_op(8'h35, 8'h36);
    run_op(8'hA5, 8'hA5);
    run_op(8'h01, 8'h02);
    run_op(8'h00, 8'h00);
    run_op(8'hFF, 8'hFE);

    // Abort in the third scan cycle.
    bus.start = 1'b1;
    bus.a = 8'hC3;
    bus.b = 8'hC3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_max", bus.max_out, 0);
    chk("abort_gt", bus.a_gt_b, 0);
    chk("abort_eq", bus.equal, 0);
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", bus.done, 0);
    end
    run_op(8'h10, 8'h01);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op(ra, rb);
    end

    // Start held high: re-accept only from IDLE after each done.
    bus.start = 1'b1;
    bus.a = 8'h3C;
    bus.b = 8'h3C;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      cyc = 1;
      got = 0;
      while (!got && cyc <= W + 4) begin
        if (bus.done) begin
          got = 1;
        end else begin
          @(posedge clk);
          #1;
          cyc++;
        end
      end
      if (!got) chk("b2b_timeout", 0, 1);
      chk("b2b_lat", cyc, W + 1);
      if (n == 2) bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_idle", bus.busy, 0);
      chk("b2b_nodone", bus.done, 0);
      @(posedge clk);
      #1;
      chk("b2b_accept", bus.busy, n < 2);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
